// File: rtl/inta_cascade_responder.sv
// 8259A (8086 mode) INTA responder: decodes the two-pulse acknowledge,
// drives the cascade bus as master and places the vector when this device owns it.
module inta_cascade_responder #(
  parameter int GAP_TIMEOUT = 64
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       INTA_n,
  input  logic       SP,
  input  logic       SNGL,
  input  logic       AEOI,
  input  logic [4:0] ICW2_T,
  input  logic [7:0] ICW3,
  input  logic       int_req,
  input  logic [2:0] irq_level,
  input  logic [2:0] CAS_in,
  output logic [2:0] CAS_out,
  output logic       CAS_oe,
  output logic [7:0] DATA_out,
  output logic       DATA_oe,
  output logic       isr_set,
  output logic [2:0] isr_level,
  output logic       eoi_auto,
  output logic       timeout,
  output logic       busy
);

  localparam int CW = $clog2(GAP_TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ACK1 = 2'd1,
    S_GAP  = 2'd2,
    S_ACK2 = 2'd3
  } state_t;

  state_t        state_q;
  logic          inta_q;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic          own_q,   own_d;
  logic          cas_q,   cas_d;
  logic          valid_q, valid_d;
  logic [2:0]    lvl_q,   lvl_d;
  logic          aeoi_q;
  logic [4:0]    t_q;
  logic          isr_set_q, eoi_q, timeout_q, cas_oe_q, data_oe_q;
  logic          fall, rise, match;

  always_comb begin
    fall    = inta_q & ~INTA_n;
    rise    = ~inta_q & INTA_n;
    match   = (CAS_in == ICW3[2:0]);
    own_d   = (SP & (SNGL | ~ICW3[irq_level])) | (SP & ~int_req) |
              (~SP & ~SNGL & match & int_req);
    cas_d   = SP & ~SNGL & int_req & ICW3[irq_level];
    valid_d = int_req & (SP | match);
    lvl_d   = int_req ? irq_level : 3'd7;
    cnt_d   = cnt_q + CW'(1);
  end

  // Transaction fields are frozen at ACK1 entry so later ICW/request changes cannot disturb the cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      inta_q    <= 1'b1;
      cnt_q     <= '0;
      own_q     <= 1'b0;
      cas_q     <= 1'b0;
      valid_q   <= 1'b0;
      lvl_q     <= 3'd0;
      aeoi_q    <= 1'b0;
      t_q       <= 5'd0;
      isr_set_q <= 1'b0;
      eoi_q     <= 1'b0;
      timeout_q <= 1'b0;
      cas_oe_q  <= 1'b0;
      data_oe_q <= 1'b0;
    end else begin
      inta_q    <= INTA_n;
      isr_set_q <= 1'b0;
      eoi_q     <= 1'b0;
      timeout_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (fall) begin
            state_q   <= S_ACK1;
            own_q     <= own_d;
            cas_q     <= cas_d;
            valid_q   <= valid_d;
            lvl_q     <= lvl_d;
            aeoi_q    <= AEOI;
            t_q       <= ICW2_T;
            isr_set_q <= valid_d;
            cas_oe_q  <= cas_d;
          end
        end
        S_ACK1: begin
          if (rise) begin
            state_q <= S_GAP;
            cnt_q   <= '0;
          end
        end
        S_GAP: begin
          // A fall on the expiry edge still completes the acknowledge.
          if (fall) begin
            state_q   <= S_ACK2;
            data_oe_q <= own_q;
          end else begin
            cnt_q <= cnt_d;
            if (cnt_d == CW'(GAP_TIMEOUT)) begin
              state_q   <= S_IDLE;
              timeout_q <= 1'b1;
              cas_oe_q  <= 1'b0;
            end
          end
        end
        S_ACK2: begin
          if (rise) begin
            state_q   <= S_IDLE;
            data_oe_q <= 1'b0;
            cas_oe_q  <= 1'b0;
            eoi_q     <= aeoi_q & valid_q;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign CAS_oe    = cas_oe_q;
  assign CAS_out   = cas_oe_q ? lvl_q : 3'd0;
  assign DATA_oe   = data_oe_q;
  assign DATA_out  = data_oe_q ? {t_q, lvl_q} : 8'd0;
  assign isr_set   = isr_set_q;
  assign isr_level = lvl_q;
  assign eoi_auto  = eoi_q;
  assign timeout   = timeout_q;
  assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_inta_cascade_responder.sv
// Directed bench for inta_cascade_responder: per-cycle reference model check
// plus hand-computed per-scenario expectations.
module tb_inta_cascade_responder;

  logic       clk;
  logic       rst_n;
  logic       INTA_n;
  logic       SP, SNGL, AEOI;
  logic [4:0] ICW2_T;
  logic [7:0] ICW3;
  logic       int_req;
  logic [2:0] irq_level;
  logic [2:0] CAS_in;
  logic [2:0] CAS_out;
  logic       CAS_oe;
  logic [7:0] DATA_out;
  logic       DATA_oe;
  logic       isr_set;
  logic [2:0] isr_level;
  logic       eoi_auto;
  logic       timeout;
  logic       busy;

  inta_cascade_responder #(.GAP_TIMEOUT(64)) dut (
    .clk(clk), .rst_n(rst_n), .INTA_n(INTA_n), .SP(SP), .SNGL(SNGL), .AEOI(AEOI),
    .ICW2_T(ICW2_T), .ICW3(ICW3), .int_req(int_req), .irq_level(irq_level),
    .CAS_in(CAS_in), .CAS_out(CAS_out), .CAS_oe(CAS_oe), .DATA_out(DATA_out),
    .DATA_oe(DATA_oe), .isr_set(isr_set), .isr_level(isr_level),
    .eoi_auto(eoi_auto), .timeout(timeout), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: tracks which INTA pulse the CPU is in and the frozen transaction.
  int         m_phase = 0;   // 0 none, 1 first pulse, 2 between pulses, 3 second pulse
  int         m_gap   = 0;
  logic       m_prev  = 1'b1;
  logic       m_own = 0, m_cas = 0, m_valid = 0, m_aeoi = 0;
  logic [2:0] m_lvl = 0;
  logic [4:0] m_t = 0;
  logic       m_isr = 0, m_eoi = 0, m_to = 0;

  // Per-scenario records of what the DUT showed.
  int         cyc = 0;
  int         rec_isr, rec_eoi, rec_to, rec_isr_cyc, rec_to_cyc;
  logic [2:0] rec_lvl;
  logic       rec_data_seen, rec_cas_seen;
  logic [7:0] rec_data;
  logic [2:0] rec_cas;

  task automatic clear_rec();
    rec_isr = 0; rec_eoi = 0; rec_to = 0; rec_isr_cyc = 0; rec_to_cyc = 0;
    rec_lvl = 0; rec_data_seen = 0; rec_cas_seen = 0; rec_data = 0; rec_cas = 0;
  endtask

  always begin
    logic r, ia, fall, rise;
    logic [2:0] exp_cas_out;
    logic [7:0] exp_data;
    @(posedge clk);
    r = rst_n; ia = INTA_n;
    fall = m_prev & ~ia;
    rise = ~m_prev & ia;
    m_isr = 0; m_eoi = 0; m_to = 0;
    if (!r) begin
      m_phase = 0; m_prev = 1'b1; m_gap = 0; m_lvl = 0; m_cas = 0; m_own = 0; m_valid = 0;
    end else begin
      if (m_phase == 0 && fall) begin
        m_valid = int_req && (SP || CAS_in == ICW3[2:0]);
        m_lvl   = int_req ? irq_level : 3'd7;
        m_cas   = SP && !SNGL && int_req && ICW3[irq_level];
        if (SP) m_own = SNGL || !ICW3[irq_level] || !int_req;
        else    m_own = !SNGL && int_req && CAS_in == ICW3[2:0];
        m_aeoi  = AEOI;
        m_t     = ICW2_T;
        m_isr   = m_valid;
        m_phase = 1;
      end else if (m_phase == 1 && rise) begin
        m_phase = 2; m_gap = 0;
      end else if (m_phase == 2) begin
        if (fall) m_phase = 3;
        else begin
          m_gap++;
          if (m_gap == 64) begin m_phase = 0; m_to = 1; end
        end
      end else if (m_phase == 3 && rise) begin
        m_phase = 0;
        m_eoi = m_aeoi && m_valid;
      end
      m_prev = ia;
    end
    #1;
    cyc++;
    exp_cas_out = (m_cas && m_phase != 0) ? m_lvl : 3'd0;
    exp_data    = (m_own && m_phase == 3) ? {m_t, m_lvl} : 8'd0;
    chk("busy",      busy,      (m_phase != 0));
    chk("isr_set",   isr_set,   m_isr);
    chk("isr_level", isr_level, m_lvl);
    chk("eoi_auto",  eoi_auto,  m_eoi);
    chk("timeout",   timeout,   m_to);
    chk("CAS_oe",    CAS_oe,    (m_cas && m_phase != 0));
    chk("CAS_out",   CAS_out,   exp_cas_out);
    chk("DATA_oe",   DATA_oe,   (m_own && m_phase == 3));
    chk("DATA_out",  DATA_out,  exp_data);
    if (isr_set)  begin rec_isr++; rec_lvl = isr_level; rec_isr_cyc = cyc; end
    if (eoi_auto) rec_eoi++;
    if (timeout)  begin rec_to++; rec_to_cyc = cyc; end
    if (DATA_oe)  begin rec_data_seen = 1; rec_data = DATA_out; end
    if (CAS_oe)   begin rec_cas_seen = 1; rec_cas = CAS_out; end
  end

  task automatic seq(input int low1, input int gap, input int low2, input int tail);
    INTA_n = 1'b0; repeat (low1) @(negedge clk);
    INTA_n = 1'b1; repeat (gap)  @(negedge clk);
    INTA_n = 1'b0; repeat (low2) @(negedge clk);
    INTA_n = 1'b1; repeat (tail) @(negedge clk);
  endtask

  task automatic cfg(input logic sp, input logic sngl, input logic aeoi, input logic [4:0] t,
                     input logic [7:0] icw3, input logic req, input logic [2:0] lvl,
                     input logic [2:0] cas);
    SP = sp; SNGL = sngl; AEOI = aeoi; ICW2_T = t; ICW3 = icw3;
    int_req = req; irq_level = lvl; CAS_in = cas;
  endtask

  initial begin
    rst_n = 1'b0; INTA_n = 1'b1;
    cfg(1, 1, 0, 5'b01000, 8'h00, 1, 3'd3, 3'd0);
    clear_rec();
    repeat (2) @(negedge clk);
    chk("reset_busy", busy, 0);
    chk("reset_cas_oe", CAS_oe, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Master single mode, level 3
    clear_rec();
    seq(2, 3, 2, 3);
    chk("t1_isr_cnt", rec_isr, 1);
    chk("t1_isr_lvl", rec_lvl, 3);
    chk("t1_data", {rec_data_seen, rec_data}, {1'b1, 8'h43});
    chk("t1_cas_seen", rec_cas_seen, 0);

    // Master cascade, slave on IR2; min widths, back-to-back
    cfg(1, 0, 0, 5'b01000, 8'h04, 1, 3'd2, 3'd0);
    clear_rec();
    seq(1, 1, 1, 1);
    seq(1, 1, 1, 3);
    chk("t2_isr_cnt", rec_isr, 2);
    chk("t2_isr_lvl", rec_lvl, 2);
    chk("t2_cas", {rec_cas_seen, rec_cas}, {1'b1, 3'd2});
    chk("t2_data_seen", rec_data_seen, 0);

    // Slave ID 2, matched
    cfg(0, 0, 0, 5'b01110, 8'h02, 1, 3'd5, 3'd2);
    clear_rec();
    seq(2, 2, 2, 3);
    chk("t3_isr_cnt", rec_isr, 1);
    chk("t3_isr_lvl", rec_lvl, 5);
    chk("t3_data", {rec_data_seen, rec_data}, {1'b1, 8'h75});

    // Slave ID 2, CAS addresses someone else
    CAS_in = 3'd3;
    clear_rec();
    seq(2, 2, 2, 3);
    chk("t3b_isr_cnt", rec_isr, 0);
    chk("t3b_data_seen", rec_data_seen, 0);

    // Master spurious with AEOI
    cfg(1, 0, 1, 5'b01000, 8'h04, 0, 3'd2, 3'd0);
    clear_rec();
    seq(2, 4, 2, 3);
    chk("t4_isr_cnt", rec_isr, 0);
    chk("t4_data", {rec_data_seen, rec_data}, {1'b1, 8'h47});
    chk("t4_eoi_cnt", rec_eoi, 0);

    // Valid request with AEOI
    cfg(1, 1, 1, 5'b01000, 8'h00, 1, 3'd3, 3'd0);
    clear_rec();
    seq(2, 2, 2, 3);
    chk("t5_eoi_cnt", rec_eoi, 1);

    // Gap timeout in cascade mode, then a normal sequence
    cfg(1, 0, 0, 5'b01000, 8'h04, 1, 3'd2, 3'd0);
    clear_rec();
    INTA_n = 1'b0; @(negedge clk);
    INTA_n = 1'b1; repeat (70) @(negedge clk);
    chk("t6_to_cnt", rec_to, 1);
    chk("t6_to_delay", rec_to_cyc - rec_isr_cyc, 65);
    chk("t6_busy", busy, 0);
    chk("t6_cas_oe", CAS_oe, 0);
    chk("t6_data_seen", rec_data_seen, 0);
    clear_rec();
    seq(1, 5, 1, 3);
    chk("t6b_isr_cnt", rec_isr, 1);
    chk("t6b_to_cnt", rec_to, 0);
    chk("t6b_cas", {rec_cas_seen, rec_cas}, {1'b1, 3'd2});

    // Reset during pulse 2
    cfg(1, 1, 1, 5'b01000, 8'h00, 1, 3'd1, 3'd0);
    clear_rec();
    INTA_n = 1'b0; repeat (2) @(negedge clk);
    INTA_n = 1'b1; repeat (3) @(negedge clk);
    INTA_n = 1'b0; repeat (2) @(negedge clk);
    rst_n = 1'b0; INTA_n = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    chk("t7_data_oe", DATA_oe, 0);
    chk("t7_cas_oe", CAS_oe, 0);
    chk("t7_busy", busy, 0);
    repeat (3) @(negedge clk);
    chk("t7_data", {rec_data_seen, rec_data}, {1'b1, 8'h41});
    chk("t7_eoi_cnt", rec_eoi, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
